// File: rtl/heater_bank_if.sv
// Signal bundle between the GPIO-side controller and the heater array.
// Host and heater-side inputs are driven by the master; the controller is the slave.
interface heater_bank_if #(
   parameter int NCHAN  = 16,
   parameter int DUTY_W = 8,
   parameter int CNT_W  = 16
);
   logic [NCHAN-1:0]  target_en;
   logic [DUTY_W-1:0] duty;
   logic [NCHAN-1:0]  err_clear;
   logic              cnt_clear;
   logic [NCHAN-1:0]  heater_error;
   logic [NCHAN-1:0]  heater_enable;
   logic [NCHAN-1:0]  heater_err_clear;
   logic [NCHAN-1:0]  err_sticky;
   logic [CNT_W-1:0]  err_count;
   logic              ramp_busy;

   modport master (
      output target_en, duty, err_clear, cnt_clear, heater_error,
      input  heater_enable, heater_err_clear, err_sticky, err_count, ramp_busy
   );

   modport slave (
      input  target_en, duty, err_clear, cnt_clear, heater_error,
      output heater_enable, heater_err_clear, err_sticky, err_count, ramp_busy
   );
endinterface

// File: rtl/heater_bank_ctrl.sv
// Heater bank controller: one-channel-per-tick soft start/stop, shared PWM gate, error latch/count.
// Optional HEATER_AUTO_TRIP_EN: a rising error trips its channel off until err_clear.
module heater_bank_ctrl #(
   parameter int NCHAN    = 16,
   parameter int RAMP_DIV = 1024,
   parameter int DUTY_W   = 8,
   parameter int CNT_W    = 16
) (
   input logic         clk,
   input logic         reset,
   heater_bank_if.slave bus
);
   localparam int              TW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [TW-1:0]   TICK_LAST = TW'(RAMP_DIV - 1);
   localparam int              SUM_W     = CNT_W + 7;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [TW-1:0]     tick_cnt;
   logic              tick;
   logic [DUTY_W-1:0] pwm_cnt;
   logic              pwm_on;
   logic [NCHAN-1:0]  staged, staged_nxt, eff;
   logic [NCHAN-1:0]  add_mask, drop_mask, add_bit, drop_bit;
   logic [NCHAN-1:0]  err_q, rise, sticky_r, enable_r, err_clear_r;
   logic [CNT_W-1:0]  count_r;
   logic [6:0]        rise_cnt;
   logic [SUM_W-1:0]  cnt_sum;

   assign tick   = (tick_cnt == TICK_LAST);
   assign pwm_on = (&bus.duty) | (pwm_cnt < bus.duty);
   assign rise   = bus.heater_error & ~err_q;

`ifdef HEATER_AUTO_TRIP_EN
   logic [NCHAN-1:0] trip;
   assign eff = bus.target_en & ~trip;
`else
   assign eff = bus.target_en;
`endif

   assign add_mask  = eff & ~staged;
   assign drop_mask = ~eff & staged;
   // two's-complement trick isolates the lowest pending addition
   assign add_bit   = add_mask & (~add_mask + NCHAN'(1));

   always_comb begin
      drop_bit = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (drop_mask[i]) begin
            drop_bit    = '0;
            drop_bit[i] = 1'b1;
         end
      end
   end

   always_comb begin
      staged_nxt = staged;
      if (tick) begin
         if (|add_mask) staged_nxt = staged | add_bit;
         else           staged_nxt = staged & ~drop_bit;
      end
`ifdef HEATER_AUTO_TRIP_EN
      staged_nxt = staged_nxt & ~trip;
`endif
   end

   always_comb begin
      rise_cnt = '0;
      for (int i = 0; i < NCHAN; i++) rise_cnt = rise_cnt + 7'(rise[i]);
   end

   assign cnt_sum = SUM_W'(count_r) + SUM_W'(rise_cnt);

   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt    <= '0;
         pwm_cnt     <= '0;
         staged      <= '0;
         enable_r    <= '0;
         err_clear_r <= '0;
         err_q       <= '0;
         sticky_r    <= '0;
         count_r     <= '0;
      end else begin
         tick_cnt    <= tick ? '0 : tick_cnt + TW'(1);
         pwm_cnt     <= pwm_cnt + DUTY_W'(1);
         staged      <= staged_nxt;
         enable_r    <= staged & {NCHAN{pwm_on}};
         err_clear_r <= bus.err_clear;
         err_q       <= bus.heater_error;
         // a new edge outranks a same-cycle clear
         sticky_r    <= rise | (sticky_r & ~bus.err_clear);
         if (bus.cnt_clear)               count_r <= '0;
         else if (cnt_sum > SUM_W'(CNT_MAX)) count_r <= CNT_MAX;
         else                             count_r <= cnt_sum[CNT_W-1:0];
      end
   end

`ifdef HEATER_AUTO_TRIP_EN
   always_ff @(posedge clk) begin
      if (reset) trip <= '0;
      else       trip <= rise | (trip & ~bus.err_clear);
   end
`endif

   assign bus.heater_enable    = enable_r;
   assign bus.heater_err_clear = err_clear_r;
   assign bus.err_sticky       = sticky_r;
   assign bus.err_count        = count_r;
   assign bus.ramp_busy        = (staged != eff);
endmodule

// File: tb/tb_heater_bank_ctrl.sv
// Scoreboard bench for heater_bank_ctrl: reference model pushes expected outputs per edge, monitor compares.
module tb_heater_bank_ctrl;
   localparam int NCHAN    = 8;
   localparam int RAMP_DIV = 4;
   localparam int DUTY_W   = 8;
   localparam int CNT_W    = 4;
   localparam int PWM_MOD  = 2 ** DUTY_W;
   localparam int CNT_SAT  = 2 ** CNT_W - 1;

   logic clk = 1'b0;
   logic reset;

   heater_bank_if #(.NCHAN(NCHAN), .DUTY_W(DUTY_W), .CNT_W(CNT_W)) bus ();

   heater_bank_ctrl #(.NCHAN(NCHAN), .RAMP_DIV(RAMP_DIV), .DUTY_W(DUTY_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCHAN-1:0] en;
      logic [NCHAN-1:0] ecl;
      logic [NCHAN-1:0] sticky;
      logic [NCHAN-1:0] staged;
      logic [NCHAN-1:0] trip;
      int               cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model state
   logic [NCHAN-1:0] m_staged, m_errq, m_sticky, m_en, m_ecl, m_trip;
   int               m_tick, m_pwm, m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [NCHAN-1:0] rise, eff, nst;
      bit   tick, on;
      int   lo, hi;
      exp_t e;
      if (reset) begin
         m_staged = '0; m_errq = '0; m_sticky = '0; m_en = '0; m_ecl = '0; m_trip = '0;
         m_tick = 0; m_pwm = 0; m_cnt = 0;
      end else begin
         tick   = (m_tick == RAMP_DIV - 1);
         m_tick = (m_tick + 1) % RAMP_DIV;
         on     = (int'(bus.duty) == PWM_MOD - 1) || (m_pwm < int'(bus.duty));
         m_pwm  = (m_pwm + 1) % PWM_MOD;
         m_en   = on ? m_staged : '0;
         m_ecl  = bus.err_clear;
         rise   = bus.heater_error & ~m_errq;
         m_errq = bus.heater_error;
`ifdef HEATER_AUTO_TRIP_EN
         eff = bus.target_en & ~m_trip;
`else
         eff = bus.target_en;
`endif
         nst = m_staged;
         if (tick) begin
            lo = -1; hi = -1;
            for (int i = 0; i < NCHAN; i++) begin
               if (eff[i] && !nst[i] && lo < 0) lo = i;
               if (!eff[i] && nst[i]) hi = i;
            end
            if (lo >= 0)      nst[lo] = 1'b0 | 1'b1;
            else if (hi >= 0) nst[hi] = 1'b0;
         end
`ifdef HEATER_AUTO_TRIP_EN
         nst    = nst & ~m_trip;
         m_trip = rise | (m_trip & ~bus.err_clear);
`endif
         m_staged = nst;
         m_sticky = rise | (m_sticky & ~bus.err_clear);
         if (bus.cnt_clear) m_cnt = 0;
         else               m_cnt = (m_cnt + $countones(rise) > CNT_SAT) ? CNT_SAT : m_cnt + $countones(rise);
      end
      e.en = m_en; e.ecl = m_ecl; e.sticky = m_sticky; e.staged = m_staged; e.trip = m_trip; e.cnt = m_cnt;
      sb_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("heater_enable",    64'(bus.heater_enable),    64'(e.en));
         chk("heater_err_clear", 64'(bus.heater_err_clear), 64'(e.ecl));
         chk("err_sticky",       64'(bus.err_sticky),       64'(e.sticky));
         chk("err_count",        64'(bus.err_count),        64'(e.cnt));
         chk("ramp_busy",        64'(bus.ramp_busy),        64'(e.staged != (bus.target_en & ~e.trip)));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int hi_cnt;
      reset = 1'b1;
      bus.target_en = '0; bus.duty = 8'hFF; bus.err_clear = '0;
      bus.cnt_clear = 1'b0; bus.heater_error = '0;
      step(3);
      reset = 1'b0;

      // soft-start to 0x0F
      bus.target_en = 8'h0F;
      step(24);
      @(negedge clk);
      chk("ramp_up_done", 64'(bus.heater_enable), 64'h0F);
      chk("ramp_up_idle", 64'(bus.ramp_busy), 64'h0);
      step(1);

      // soft-stop, then new request mid-ramp
      bus.target_en = 8'h00;
      step(10);
      bus.target_en = 8'h03;
      step(24);
      @(negedge clk);
      chk("ramp_resume", 64'(bus.heater_enable), 64'h03);
      step(1);

      // PWM duty 64 of 256 on channel 0
      bus.target_en = 8'h01;
      bus.duty = 8'd64;
      step(12);
      hi_cnt = 0;
      repeat (PWM_MOD) begin
         @(negedge clk);
         if (bus.heater_enable[0]) hi_cnt++;
      end
      chk("pwm_duty64_count", 64'(hi_cnt), 64'd64);
      step(1);
      bus.duty = 8'd0;
      step(20);
      bus.duty = 8'hFF;
      step(20);

      // error edges: two at once, then set-beats-clear, then saturation
      bus.heater_error = 8'h05;
      step(2);
      bus.heater_error = 8'h00;
      step(1);
      bus.heater_error = 8'h01; bus.err_clear = 8'h01;
      step(1);
      bus.heater_error = 8'h00; bus.err_clear = 8'h00;
      step(1);
      for (int k = 0; k < 20; k++) begin
         bus.heater_error = 8'h08;
         step(1);
         bus.heater_error = 8'h00;
         step(1);
      end
      @(negedge clk);
      chk("err_count_sat", 64'(bus.err_count), 64'(CNT_SAT));
      step(1);
      bus.cnt_clear = 1'b1;
      step(1);
      bus.cnt_clear = 1'b0; bus.err_clear = 8'hFF;
      step(1);
      bus.err_clear = 8'h00;
      step(2);

      // reset mid-ramp
      reset = 1'b1;
      step(1);
      reset = 1'b0; bus.target_en = 8'h0F;
      step(9);
      reset = 1'b1;
      step(1);
      @(negedge clk);
      chk("reset_mid_ramp_en",  64'(bus.heater_enable), 64'h0);
      chk("reset_mid_ramp_cnt", 64'(bus.err_count), 64'h0);
      step(1);
      reset = 1'b0;
      step(30);

`ifdef HEATER_AUTO_TRIP_EN
      bus.heater_error = 8'h04;
      step(3);
      @(negedge clk);
      chk("trip_ch2_off", 64'(bus.heater_enable), 64'h0B);
      step(1);
      bus.heater_error = 8'h00; bus.err_clear = 8'h04;
      step(1);
      bus.err_clear = 8'h00;
      step(12);
      @(negedge clk);
      chk("trip_ch2_back", 64'(bus.heater_enable), 64'h0F);
      step(1);
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) bus.target_en = NCHAN'($urandom);
         if ($urandom_range(0, 99) == 0) bus.duty = DUTY_W'($urandom);
         bus.heater_error = ($urandom_range(0, 3) == 0) ? NCHAN'($urandom) & NCHAN'($urandom) : bus.heater_error;
         bus.err_clear    = ($urandom_range(0, 9) == 0) ? NCHAN'($urandom) : '0;
         bus.cnt_clear    = ($urandom_range(0, 63) == 0);
         reset            = ($urandom_range(0, 499) == 0);
         step(1);
      end
      reset = 1'b0;
      step(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/heater_bank_ctrl.md
Name: heater_bank_ctrl

Overview:
Controller for a bank of NCHAN heater instances. It sits between the processor GPIO and the heater array. Requested enables are applied one channel at a time (soft-start/soft-stop) to limit supply load steps. A shared PWM gate throttles power. Per-channel error status is latched, counted and cleared.

Parameters:
NCHAN, 16, number of heater channels (1..64)
RAMP_DIV, 1024, clk cycles between successive single-channel enable changes (>=1)
DUTY_W, 8, PWM counter/duty width
CNT_W, 16, width of saturating error-event counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
target_en  input  NCHAN  software-requested channel enables
duty  input  DUTY_W  PWM on-time; 0 = off, all-ones = always on
err_clear  input  NCHAN  per-channel clear request (level, sampled each cycle)
cnt_clear  input  1  clears err_count
heater_error  input  NCHAN  raw per-channel error from heater instances
heater_enable  output  NCHAN  registered enables to heater instances
heater_err_clear  output  NCHAN  registered copy of err_clear to heater instances
err_sticky  output  NCHAN  latched per-channel error
err_count  output  CNT_W  total error rising edges, saturating
ramp_busy  output  1  staged mask != effective target

Behaviour:
- Reset: heater_enable, heater_err_clear, err_sticky, err_count, ramp_busy, staged mask, tick counter, PWM counter, heater_error history all 0. Reset mid-ramp drops every enable on the next edge; no ramp-down.
- Tick: counter counts 0..RAMP_DIV-1, then wraps; tick=1 on the wrap cycle. With RAMP_DIV=1, tick every cycle. Counter free-runs, including when idle.
- Effective target eff = target_en (masked by trip; see Optional Feature).
- On tick, at most one staged bit changes. Additions take priority:
  - if any bit has eff=1 and staged=0: set the lowest such index;
  - else if any bit has eff=0 and staged=1: clear the highest such index;
  - else no change.
- target_en may change at any time. Only the value at the tick is used; no queueing.
- ramp_busy = (staged != eff), combinational from registers and target_en.
- PWM: DUTY_W-bit counter increments every cycle and wraps. pwm_on = (duty == all-ones) | (pwm_cnt < duty).
- heater_enable <= staged & {NCHAN{pwm_on}}. One cycle latency from staged/pwm_on.
- heater_err_clear <= err_clear (one-cycle delay).
- Error edge: rise[i] = heater_error[i] & ~heater_error_q[i].
- err_sticky[i] <= rise[i] | (err_sticky[i] & ~err_clear[i]). If set and clear hit the same bit in the same cycle, set wins.
- err_count <= cnt_clear ? 0 : min(err_count + popcount(rise), 2^CNT_W-1). Several edges in one cycle all count. Saturation holds at max. cnt_clear beats same-cycle edges.
- heater_error is treated as already synchronous to clk; no synchroniser in this block.

Optional Feature:
HEATER_AUTO_TRIP_EN
- Defined: per-channel trip register. trip[i] sets on rise[i] and clears when err_clear[i]=1 and rise[i]=0.
- A tripped channel's staged bit is cleared on the next edge, bypassing tick and one-change rules. eff = target_en & ~trip.
- After the clear, the channel re-enters through the normal soft-start ramp.
- Undefined: no trip register; eff = target_en; errors never affect enables.

Test Plan:
- RAMP_DIV=4, duty=all-ones, target_en 0x0000->0x000F: heater_enable steps 0x1,0x3,0x7,0xF at 4-cycle spacing; ramp_busy drops when 0xF is staged.
- Staged 0x000F, target_en->0x0000: enables clear in order 0x7,0x3,0x1,0x0, one per tick. Then target 0x0003 while ramping down: additions resume first.
- DUTY_W=8, duty=64, staged 0x1: heater_enable[0] high 64 of every 256 cycles. duty=0 -> always low. duty=255 -> always high.
- heater_error 0x0005 rises in one cycle: err_count +=2, err_sticky=0x0005. err_clear=0x0001 with a new rise on bit0 in the same cycle: bit0 stays set. CNT_W=4: 20 edges saturate at 15. cnt_clear -> 0.
- Assert reset mid-ramp (staged 0x3 toward 0xF): next cycle all outputs 0. Release: ramp restarts from 0x0.
- HEATER_AUTO_TRIP_EN, staged 0xF, error on ch2: heater_enable[2] low within 2 cycles, others unaffected. After err_clear[2], ch2 re-enables on a later tick.
